// File: rtl/axi_ram_write_slave.sv
// axi_ram_write_slave: AXI4 write slave committing bursts to a word-addressed RAM write port
module axi_ram_write_slave #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4,
  parameter int RAM_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_W-1:0]       axi_aw_awid,
  input  logic [ADDR_W-1:0]     axi_aw_awaddr,
  input  logic [2:0]            axi_aw_awsize,
  input  logic [7:0]            axi_aw_awlen,
  input  logic [1:0]            axi_aw_awburst,
  input  logic                  axi_aw_awvalid,
  output logic                  axi_aw_awready,
  input  logic [DATA_W-1:0]     axi_w_wdata,
  input  logic [DATA_W/8-1:0]   axi_w_wstrb,
  input  logic                  axi_w_wlast,
  input  logic                  axi_w_wvalid,
  output logic                  axi_w_wready,
  output logic [2:0]            axi_b_bresp,
  output logic [ID_W-1:0]       axi_b_bid,
  output logic                  axi_b_bvalid,
  input  logic                  axi_b_bready,
  output logic                  ram_wr_en,
  output logic [RAM_ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0]     ram_wr_data,
  output logic [DATA_W/8-1:0]   ram_wr_mask
);
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0] id;
  logic [7:0] len, cnt;
  logic [1:0] burst, err, aw_err;
  logic [RAM_ADDR_W-1:0] addr;
  logic aw_hs, w_hs, b_hs, at_len, unused;
  assign aw_hs  = axi_aw_awvalid & axi_aw_awready;
  assign w_hs   = axi_w_wvalid & axi_w_wready;
  assign b_hs   = axi_b_bvalid & axi_b_bready;
  assign at_len = cnt == len;
  assign unused = ^axi_aw_awaddr[1:0];
  // out-of-range address wins over unsupported size/burst
  assign aw_err = |axi_aw_awaddr[ADDR_W-1:RAM_ADDR_W+2] ? 2'd3 :
                  (axi_aw_awsize != 3'd2 || axi_aw_awburst[1]) ? 2'd2 : 2'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (aw_hs ? DATA : IDLE) :
               state == DATA ? (w_hs && (axi_w_wlast || at_len) ? RESP : DATA) :
               (b_hs ? IDLE : RESP);
  end
  // awready is gated by rst so it stays low for the whole reset pulse
  always_comb begin
    axi_aw_awready = state == IDLE && !rst;
    axi_w_wready   = state == DATA;
    axi_b_bvalid   = state == RESP;
    axi_b_bid      = axi_b_bvalid ? id : '0;
    axi_b_bresp    = axi_b_bvalid ? {1'b0, err} : 3'd0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      id          <= '0;
      len         <= '0;
      cnt         <= '0;
      burst       <= '0;
      err         <= '0;
      addr        <= '0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      ram_wr_mask <= '0;
    end else begin
      ram_wr_en   <= w_hs && err == 2'd0 && |axi_w_wstrb;
      ram_wr_addr <= addr;
      ram_wr_data <= axi_w_wdata;
      ram_wr_mask <= axi_w_wstrb;
      if (aw_hs) begin
        id    <= axi_aw_awid;
        len   <= axi_aw_awlen;
        burst <= axi_aw_awburst;
        addr  <= axi_aw_awaddr[RAM_ADDR_W+1:2];
        err   <= aw_err;
        cnt   <= '0;
      end
      if (w_hs) begin
        cnt <= cnt + 8'd1;
        if (burst == 2'd1) addr <= addr + RAM_ADDR_W'(1);
        if (axi_w_wlast != at_len && err != 2'd3) err <= 2'd2;
      end
    end
endmodule
